// File: rtl/axi4lite_arb_if.sv
// rtl/axi4lite_arb_if.sv - AXI4-lite channel bundle used for the arbiter inports and outport
interface axi4lite_arb_if;
    logic        awvalid;
    logic [31:0] awaddr;
    logic        awready;
    logic        wvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wready;
    logic        bvalid;
    logic [1:0]  bresp;
    logic        bready;
    logic        arvalid;
    logic [31:0] araddr;
    logic        arready;
    logic        rvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rready;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi4lite_arb.sv
// rtl/axi4lite_arb.sv - two-master AXI4-lite arbiter with independent round-robin read and write paths
module axi4lite_arb (
    input  logic           clk_i,
    input  logic           rst_i,
    axi4lite_arb_if.slave  inport0,
    axi4lite_arb_if.slave  inport1,
    axi4lite_arb_if.master outport
);
    typedef enum logic {ST_IDLE, ST_BUSY} state_e;

    state_e wr_state_q, wr_state_d;
    logic   wr_sel_q, wr_sel_d, wr_lw_q, wr_lw_d;
    logic   aw_done_q, aw_done_d, w_done_q, w_done_d;

    state_e rd_state_q, rd_state_d;
    logic   rd_sel_q, rd_sel_d, rd_lw_q, rd_lw_d;
    logic   ar_done_q, ar_done_d;

    logic wr_busy, wr_g0, wr_g1, wr_pick;
    logic rd_busy, rd_g0, rd_g1, rd_pick;
    logic out_awvalid, out_wvalid, out_bready, out_arvalid, out_rready;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_state_q <= ST_IDLE;
            wr_sel_q   <= 1'b0;
            wr_lw_q    <= 1'b1;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            rd_state_q <= ST_IDLE;
            rd_sel_q   <= 1'b0;
            rd_lw_q    <= 1'b1;
            ar_done_q  <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            wr_sel_q   <= wr_sel_d;
            wr_lw_q    <= wr_lw_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            rd_state_q <= rd_state_d;
            rd_sel_q   <= rd_sel_d;
            rd_lw_q    <= rd_lw_d;
            ar_done_q  <= ar_done_d;
        end
    end

    // On a tie the port that did not win last time is chosen.
    assign wr_pick = (inport0.awvalid & inport1.awvalid) ? ~wr_lw_q : inport1.awvalid;
    assign rd_pick = (inport0.arvalid & inport1.arvalid) ? ~rd_lw_q : inport1.arvalid;

    assign wr_busy = (wr_state_q == ST_BUSY);
    assign wr_g0   = wr_busy & ~wr_sel_q;
    assign wr_g1   = wr_busy &  wr_sel_q;
    assign rd_busy = (rd_state_q == ST_BUSY);
    assign rd_g0   = rd_busy & ~rd_sel_q;
    assign rd_g1   = rd_busy &  rd_sel_q;

    assign out_awvalid = ((wr_g0 & inport0.awvalid) | (wr_g1 & inport1.awvalid)) & ~aw_done_q;
    assign out_wvalid  = ((wr_g0 & inport0.wvalid)  | (wr_g1 & inport1.wvalid))  & ~w_done_q;
    assign out_bready  =  (wr_g0 & inport0.bready)  | (wr_g1 & inport1.bready);
    assign out_arvalid = ((rd_g0 & inport0.arvalid) | (rd_g1 & inport1.arvalid)) & ~ar_done_q;
    assign out_rready  =  (rd_g0 & inport0.rready)  | (rd_g1 & inport1.rready);

    assign aw_hs = out_awvalid & outport.awready;
    assign w_hs  = out_wvalid  & outport.wready;
    assign b_hs  = out_bready  & outport.bvalid;
    assign ar_hs = out_arvalid & outport.arready;
    assign r_hs  = out_rready  & outport.rvalid;

    always_comb begin
        wr_state_d = wr_state_q;
        wr_sel_d   = wr_sel_q;
        wr_lw_d    = wr_lw_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        case (wr_state_q)
            ST_IDLE: begin
                if (inport0.awvalid | inport1.awvalid) begin
                    wr_state_d = ST_BUSY;
                    wr_sel_d   = wr_pick;
                    wr_lw_d    = wr_pick;
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                end
            end
            ST_BUSY: begin
                if (b_hs) begin
                    wr_state_d = ST_IDLE;
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                end else begin
                    aw_done_d = aw_done_q | aw_hs;
                    w_done_d  = w_done_q | w_hs;
                end
            end
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rd_sel_d   = rd_sel_q;
        rd_lw_d    = rd_lw_q;
        ar_done_d  = ar_done_q;
        case (rd_state_q)
            ST_IDLE: begin
                if (inport0.arvalid | inport1.arvalid) begin
                    rd_state_d = ST_BUSY;
                    rd_sel_d   = rd_pick;
                    rd_lw_d    = rd_pick;
                    ar_done_d  = 1'b0;
                end
            end
            ST_BUSY: begin
                if (r_hs) begin
                    rd_state_d = ST_IDLE;
                    ar_done_d  = 1'b0;
                end else begin
                    ar_done_d = ar_done_q | ar_hs;
                end
            end
        endcase
    end

    // Downstream request side: fields come from the granted port, zero while idle.
    assign outport.awvalid = out_awvalid;
    assign outport.awaddr  = wr_g0 ? inport0.awaddr : (wr_g1 ? inport1.awaddr : 32'h0);
    assign outport.wvalid  = out_wvalid;
    assign outport.wdata   = wr_g0 ? inport0.wdata  : (wr_g1 ? inport1.wdata  : 32'h0);
    assign outport.wstrb   = wr_g0 ? inport0.wstrb  : (wr_g1 ? inport1.wstrb  : 4'h0);
    assign outport.bready  = out_bready;
    assign outport.arvalid = out_arvalid;
    assign outport.araddr  = rd_g0 ? inport0.araddr : (rd_g1 ? inport1.araddr : 32'h0);
    assign outport.rready  = out_rready;

    assign inport0.awready = wr_g0 & outport.awready & ~aw_done_q;
    assign inport0.wready  = wr_g0 & outport.wready  & ~w_done_q;
    assign inport0.bvalid  = wr_g0 & outport.bvalid;
    assign inport0.bresp   = wr_g0 ? outport.bresp : 2'b00;
    assign inport0.arready = rd_g0 & outport.arready & ~ar_done_q;
    assign inport0.rvalid  = rd_g0 & outport.rvalid;
    assign inport0.rdata   = rd_g0 ? outport.rdata : 32'h0;
    assign inport0.rresp   = rd_g0 ? outport.rresp : 2'b00;

    assign inport1.awready = wr_g1 & outport.awready & ~aw_done_q;
    assign inport1.wready  = wr_g1 & outport.wready  & ~w_done_q;
    assign inport1.bvalid  = wr_g1 & outport.bvalid;
    assign inport1.bresp   = wr_g1 ? outport.bresp : 2'b00;
    assign inport1.arready = rd_g1 & outport.arready & ~ar_done_q;
    assign inport1.rvalid  = rd_g1 & outport.rvalid;
    assign inport1.rdata   = rd_g1 ? outport.rdata : 32'h0;
    assign inport1.rresp   = rd_g1 ? outport.rresp : 2'b00;
endmodule

// File: tb/tb_axi4lite_arb.sv
// tb/tb_axi4lite_arb.sv - self-checking bench for axi4lite_arb against a transaction-level model
module tb_axi4lite_arb;
    logic clk_i;
    logic rst_i;

    axi4lite_arb_if in0_if ();
    axi4lite_arb_if in1_if ();
    axi4lite_arb_if out_if ();

    axi4lite_arb dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inport0 (in0_if),
        .inport1 (in1_if),
        .outport (out_if)
    );

    logic        m_awvalid[2];
    logic [31:0] m_awaddr[2];
    logic        m_wvalid[2];
    logic [31:0] m_wdata[2];
    logic [3:0]  m_wstrb[2];
    logic        m_bready[2];
    logic        m_arvalid[2];
    logic [31:0] m_araddr[2];
    logic        m_rready[2];

    logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
    logic [1:0]  s_bresp, s_rresp;
    logic [31:0] s_rdata;

    logic        d_awready[2], d_wready[2], d_bvalid[2], d_arready[2], d_rvalid[2];
    logic [1:0]  d_bresp[2], d_rresp[2];
    logic [31:0] d_rdata[2];

    assign in0_if.awvalid = m_awvalid[0];
    assign in0_if.awaddr  = m_awaddr[0];
    assign in0_if.wvalid  = m_wvalid[0];
    assign in0_if.wdata   = m_wdata[0];
    assign in0_if.wstrb   = m_wstrb[0];
    assign in0_if.bready  = m_bready[0];
    assign in0_if.arvalid = m_arvalid[0];
    assign in0_if.araddr  = m_araddr[0];
    assign in0_if.rready  = m_rready[0];
    assign in1_if.awvalid = m_awvalid[1];
    assign in1_if.awaddr  = m_awaddr[1];
    assign in1_if.wvalid  = m_wvalid[1];
    assign in1_if.wdata   = m_wdata[1];
    assign in1_if.wstrb   = m_wstrb[1];
    assign in1_if.bready  = m_bready[1];
    assign in1_if.arvalid = m_arvalid[1];
    assign in1_if.araddr  = m_araddr[1];
    assign in1_if.rready  = m_rready[1];

    assign out_if.awready = s_awready;
    assign out_if.wready  = s_wready;
    assign out_if.bvalid  = s_bvalid;
    assign out_if.bresp   = s_bresp;
    assign out_if.arready = s_arready;
    assign out_if.rvalid  = s_rvalid;
    assign out_if.rdata   = s_rdata;
    assign out_if.rresp   = s_rresp;

    assign d_awready[0] = in0_if.awready;
    assign d_wready[0]  = in0_if.wready;
    assign d_bvalid[0]  = in0_if.bvalid;
    assign d_bresp[0]   = in0_if.bresp;
    assign d_arready[0] = in0_if.arready;
    assign d_rvalid[0]  = in0_if.rvalid;
    assign d_rdata[0]   = in0_if.rdata;
    assign d_rresp[0]   = in0_if.rresp;
    assign d_awready[1] = in1_if.awready;
    assign d_wready[1]  = in1_if.wready;
    assign d_bvalid[1]  = in1_if.bvalid;
    assign d_bresp[1]   = in1_if.bresp;
    assign d_arready[1] = in1_if.arready;
    assign d_rvalid[1]  = in1_if.rvalid;
    assign d_rdata[1]   = in1_if.rdata;
    assign d_rresp[1]   = in1_if.rresp;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 0;

    // Model: each path is either idle (owner -1) or owned by one port; *_sent marks accepted AW/W/AR.
    int w_owner, w_last, r_owner, r_last;
    bit w_aw_sent, w_w_sent, r_ar_sent;

    logic        e_awvalid, e_wvalid, e_bready, e_arvalid, e_rready;
    logic [31:0] e_awaddr, e_wdata, e_araddr;
    logic [3:0]  e_wstrb;
    logic        e_awready[2], e_wready[2], e_bvalid[2], e_arready[2], e_rvalid[2];
    logic [1:0]  e_bresp[2], e_rresp[2];
    logic [31:0] e_rdata[2];

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=0x%0h required=0x%0h", nm, $time, act, exp);
        end
    endtask

    function automatic int pick(input logic r0, input logic r1, input int last);
        if (r0 && r1) return 1 - last;
        if (r0) return 0;
        if (r1) return 1;
        return -1;
    endfunction

    task automatic model_expect();
        e_awvalid = 0; e_awaddr = 0; e_wvalid = 0; e_wdata = 0; e_wstrb = 0; e_bready = 0;
        e_arvalid = 0; e_araddr = 0; e_rready = 0;
        for (int p = 0; p < 2; p++) begin
            e_awready[p] = 0; e_wready[p] = 0; e_bvalid[p] = 0; e_bresp[p] = 0;
            e_arready[p] = 0; e_rvalid[p] = 0; e_rdata[p] = 0; e_rresp[p] = 0;
        end
        if (!rst_i && w_owner >= 0) begin
            e_awvalid = m_awvalid[w_owner] && !w_aw_sent;
            e_awaddr  = m_awaddr[w_owner];
            e_wvalid  = m_wvalid[w_owner] && !w_w_sent;
            e_wdata   = m_wdata[w_owner];
            e_wstrb   = m_wstrb[w_owner];
            e_bready  = m_bready[w_owner];
            e_awready[w_owner] = s_awready && !w_aw_sent;
            e_wready[w_owner]  = s_wready && !w_w_sent;
            e_bvalid[w_owner]  = s_bvalid;
            e_bresp[w_owner]   = s_bresp;
        end
        if (!rst_i && r_owner >= 0) begin
            e_arvalid = m_arvalid[r_owner] && !r_ar_sent;
            e_araddr  = m_araddr[r_owner];
            e_rready  = m_rready[r_owner];
            e_arready[r_owner] = s_arready && !r_ar_sent;
            e_rvalid[r_owner]  = s_rvalid;
            e_rdata[r_owner]   = s_rdata;
            e_rresp[r_owner]   = s_rresp;
        end
    endtask

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            w_owner <= -1; w_last <= 1; w_aw_sent <= 0; w_w_sent <= 0;
            r_owner <= -1; r_last <= 1; r_ar_sent <= 0;
        end else begin
            if (w_owner < 0) begin
                if (pick(m_awvalid[0], m_awvalid[1], w_last) >= 0) begin
                    w_owner   <= pick(m_awvalid[0], m_awvalid[1], w_last);
                    w_last    <= pick(m_awvalid[0], m_awvalid[1], w_last);
                    w_aw_sent <= 0;
                    w_w_sent  <= 0;
                end
            end else if (s_bvalid && m_bready[w_owner]) begin
                w_owner <= -1; w_aw_sent <= 0; w_w_sent <= 0;
            end else begin
                w_aw_sent <= w_aw_sent || (m_awvalid[w_owner] && s_awready);
                w_w_sent  <= w_w_sent || (m_wvalid[w_owner] && s_wready);
            end
            if (r_owner < 0) begin
                if (pick(m_arvalid[0], m_arvalid[1], r_last) >= 0) begin
                    r_owner   <= pick(m_arvalid[0], m_arvalid[1], r_last);
                    r_last    <= pick(m_arvalid[0], m_arvalid[1], r_last);
                    r_ar_sent <= 0;
                end
            end else if (s_rvalid && m_rready[r_owner]) begin
                r_owner <= -1; r_ar_sent <= 0;
            end else begin
                r_ar_sent <= r_ar_sent || (m_arvalid[r_owner] && s_arready);
            end
        end
    end

    always @(negedge clk_i) begin
        #2;
        if (cmp_en) begin
            model_expect();
            chk("out_awvalid", out_if.awvalid, e_awvalid);
            chk("out_awaddr",  out_if.awaddr,  e_awaddr);
            chk("out_wvalid",  out_if.wvalid,  e_wvalid);
            chk("out_wdata",   out_if.wdata,   e_wdata);
            chk("out_wstrb",   out_if.wstrb,   e_wstrb);
            chk("out_bready",  out_if.bready,  e_bready);
            chk("out_arvalid", out_if.arvalid, e_arvalid);
            chk("out_araddr",  out_if.araddr,  e_araddr);
            chk("out_rready",  out_if.rready,  e_rready);
            for (int p = 0; p < 2; p++) begin
                chk($sformatf("p%0d_awready", p), d_awready[p], e_awready[p]);
                chk($sformatf("p%0d_wready", p),  d_wready[p],  e_wready[p]);
                chk($sformatf("p%0d_bvalid", p),  d_bvalid[p],  e_bvalid[p]);
                chk($sformatf("p%0d_bresp", p),   d_bresp[p],   e_bresp[p]);
                chk($sformatf("p%0d_arready", p), d_arready[p], e_arready[p]);
                chk($sformatf("p%0d_rvalid", p),  d_rvalid[p],  e_rvalid[p]);
                chk($sformatf("p%0d_rdata", p),   d_rdata[p],   e_rdata[p]);
                chk($sformatf("p%0d_rresp", p),   d_rresp[p],   e_rresp[p]);
            end
        end
    end

    task automatic clear_inputs();
        for (int p = 0; p < 2; p++) begin
            m_awvalid[p] = 0; m_awaddr[p] = 0; m_wvalid[p] = 0; m_wdata[p] = 0; m_wstrb[p] = 0;
            m_bready[p] = 0; m_arvalid[p] = 0; m_araddr[p] = 0; m_rready[p] = 0;
        end
        s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = 0;
        s_arready = 0; s_rvalid = 0; s_rdata = 0; s_rresp = 0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        clear_inputs();
        rst_i = 1;
        @(negedge clk_i);
        rst_i = 0;
    endtask

    initial begin
        rst_i = 1;
        clear_inputs();
        @(negedge clk_i);
        // Requests and responses active during reset must not leak through.
        for (int p = 0; p < 2; p++) begin
            m_awvalid[p] = 1; m_wvalid[p] = 1; m_arvalid[p] = 1; m_bready[p] = 1; m_rready[p] = 1;
        end
        s_awready = 1; s_wready = 1; s_bvalid = 1; s_arready = 1; s_rvalid = 1; s_rdata = 32'hDEAD_BEEF;
        cmp_en = 1;
        @(negedge clk_i);
        #3;
        chk("rst_out_awvalid", out_if.awvalid, 0);
        chk("rst_out_wvalid",  out_if.wvalid,  0);
        chk("rst_out_arvalid", out_if.arvalid, 0);
        chk("rst_out_bready",  out_if.bready,  0);
        chk("rst_out_rready",  out_if.rready,  0);
        chk("rst_p0_bvalid",   in0_if.bvalid,  0);
        chk("rst_p1_rvalid",   in1_if.rvalid,  0);
        chk("rst_p0_awready",  in0_if.awready, 0);
        chk("mdl_w_owner",     w_owner, -1);
        chk("mdl_r_last",      r_last, 1);

        // Read tie after reset: port0 first, then port1.
        do_reset();
        @(negedge clk_i);
        m_arvalid[0] = 1; m_araddr[0] = 32'h1000_0000;
        m_arvalid[1] = 1; m_araddr[1] = 32'h2000_0004;
        #3 chk("r040_no_comb_arvalid", out_if.arvalid, 0);
        @(negedge clk_i);
        s_arready = 1;
        #3;
        chk("r040_arvalid0", out_if.arvalid, 1);
        chk("r040_araddr0",  out_if.araddr, 32'h1000_0000);
        chk("r040_p0_arready", in0_if.arready, 1);
        chk("r040_p1_arready", in1_if.arready, 0);
        @(negedge clk_i);
        m_arvalid[0] = 0; s_arready = 0; s_rvalid = 1; s_rdata = 32'hCAFE_0001;
        m_rready[0] = 1; m_rready[1] = 1;
        #3;
        chk("r040_p0_rvalid", in0_if.rvalid, 1);
        chk("r040_p0_rdata",  in0_if.rdata, 32'hCAFE_0001);
        chk("r040_p1_rvalid", in1_if.rvalid, 0);
        chk("r040_ar_gated",  out_if.arvalid, 0);
        @(negedge clk_i);
        s_rvalid = 0;
        #3 chk("r040_idle_gap", out_if.arvalid, 0);
        @(negedge clk_i);
        s_arready = 1;
        #3;
        chk("r040_arvalid1", out_if.arvalid, 1);
        chk("r040_araddr1",  out_if.araddr, 32'h2000_0004);
        chk("r040_p1_arready", in1_if.arready, 1);
        @(negedge clk_i);
        m_arvalid[1] = 0; s_arready = 0; s_rvalid = 1; s_rdata = 32'hBEEF_0002;
        #3;
        chk("r040_p1_rdata",  in1_if.rdata, 32'hBEEF_0002);
        chk("r040_p0_rvalid2", in0_if.rvalid, 0);
        chk("r040_p0_rdata2",  in0_if.rdata, 0);

        // Port1 write with AW first and W three cycles later.
        do_reset();
        @(negedge clk_i);
        m_awvalid[1] = 1; m_awaddr[1] = 32'h3000_0008; m_bready[1] = 1;
        s_awready = 1; s_wready = 1;
        #3 chk("r041_aw_latency", out_if.awvalid, 0);
        @(negedge clk_i);
        #3;
        chk("r041_awvalid", out_if.awvalid, 1);
        chk("r041_awaddr",  out_if.awaddr, 32'h3000_0008);
        chk("r041_p1_awready", in1_if.awready, 1);
        chk("r041_p0_awready", in0_if.awready, 0);
        @(negedge clk_i);
        #3;
        chk("r041_aw_single_pulse", out_if.awvalid, 0);
        chk("r041_no_wvalid", out_if.wvalid, 0);
        @(negedge clk_i);
        m_wvalid[1] = 1; m_wdata[1] = 32'h5555_AAAA; m_wstrb[1] = 4'hF;
        #3;
        chk("r041_wvalid", out_if.wvalid, 1);
        chk("r041_wdata",  out_if.wdata, 32'h5555_AAAA);
        chk("r041_p1_wready", in1_if.wready, 1);
        @(negedge clk_i);
        m_awvalid[1] = 0; m_wvalid[1] = 0; s_bvalid = 1; s_bresp = 2'b00;
        #3;
        chk("r041_p1_bvalid", in1_if.bvalid, 1);
        chk("r041_p1_bresp",  in1_if.bresp, 2'b00);
        chk("r041_p0_bvalid", in0_if.bvalid, 0);
        chk("r041_bready",    out_if.bready, 1);
        chk("r041_w_gated",   out_if.wvalid, 0);
        @(negedge clk_i);
        s_bvalid = 0;
        #3 chk("r041_done_idle", in1_if.bvalid, 0);

        // Continuous writes from both ports: strict alternation with an idle cycle between.
        do_reset();
        @(negedge clk_i);
        for (int p = 0; p < 2; p++) begin
            m_awvalid[p] = 1; m_wvalid[p] = 1; m_bready[p] = 1;
            m_awaddr[p] = 32'h6000_0000 + p; m_wdata[p] = 32'h7000_0000 + p; m_wstrb[p] = 4'h3;
        end
        s_awready = 1; s_wready = 1; s_bvalid = 1; s_bresp = 2'b01;
        for (int i = 0; i < 8; i++) begin
            #3 chk($sformatf("r042_idle%0d", i), out_if.awvalid, 0);
            @(negedge clk_i);
            #3;
            chk($sformatf("r042_p0_gnt%0d", i), in0_if.awready, (i % 2) == 0);
            chk($sformatf("r042_p1_gnt%0d", i), in1_if.awready, (i % 2) == 1);
            chk($sformatf("r042_awaddr%0d", i), out_if.awaddr, 32'h6000_0000 + (i % 2));
            @(negedge clk_i);
        end
        clear_inputs();

        // Concurrent read on port0 and write on port1.
        do_reset();
        @(negedge clk_i);
        m_arvalid[0] = 1; m_araddr[0] = 32'h4000_0010;
        m_awvalid[1] = 1; m_awaddr[1] = 32'h5000_0020; m_wvalid[1] = 1; m_wdata[1] = 32'h1234_5678;
        m_wstrb[1] = 4'hA;
        @(negedge clk_i);
        s_arready = 1; s_awready = 1; s_wready = 1;
        #3;
        chk("r043_arvalid", out_if.arvalid, 1);
        chk("r043_awvalid", out_if.awvalid, 1);
        chk("r043_araddr",  out_if.araddr, 32'h4000_0010);
        chk("r043_awaddr",  out_if.awaddr, 32'h5000_0020);
        chk("r043_p0_arready", in0_if.arready, 1);
        chk("r043_p1_arready", in1_if.arready, 0);
        chk("r043_p1_awready", in1_if.awready, 1);
        chk("r043_p0_awready", in0_if.awready, 0);
        @(negedge clk_i);
        m_arvalid[0] = 0; m_awvalid[1] = 0; m_wvalid[1] = 0;
        s_arready = 0; s_awready = 0; s_wready = 0;
        s_rvalid = 1; s_rdata = 32'h0F0F_0F0F; s_rresp = 2'b01; s_bvalid = 1; s_bresp = 2'b10;
        for (int p = 0; p < 2; p++) begin m_rready[p] = 1; m_bready[p] = 1; end
        #3;
        chk("r043_p0_rvalid", in0_if.rvalid, 1);
        chk("r043_p0_rdata",  in0_if.rdata, 32'h0F0F_0F0F);
        chk("r043_p0_rresp",  in0_if.rresp, 2'b01);
        chk("r043_p1_rvalid", in1_if.rvalid, 0);
        chk("r043_p1_bvalid", in1_if.bvalid, 1);
        chk("r043_p1_bresp",  in1_if.bresp, 2'b10);
        chk("r043_p0_bvalid", in0_if.bvalid, 0);
        chk("r043_p0_bresp",  in0_if.bresp, 2'b00);
        @(negedge clk_i);
        clear_inputs();

        // Reset mid-write after AW accepted, W still pending.
        do_reset();
        @(negedge clk_i);
        m_awvalid[0] = 1; m_awaddr[0] = 32'h8000_0000; s_awready = 1;
        @(negedge clk_i);
        #3 chk("r044_aw_hs", in0_if.awready, 1);
        @(negedge clk_i);
        m_awvalid[0] = 0; s_awready = 0; m_wvalid[0] = 1; m_wdata[0] = 32'h9999_0000;
        #3;
        chk("r044_wvalid_before", out_if.wvalid, 1);
        rst_i = 1;
        #1;
        chk("r044_wvalid_async", out_if.wvalid, 0);
        chk("r044_p0_wready_async", in0_if.wready, 0);
        @(negedge clk_i);
        rst_i = 0; m_wvalid[0] = 0; s_bvalid = 1; m_bready[0] = 1; m_bready[1] = 1;
        #3;
        chk("r044_p0_bvalid", in0_if.bvalid, 0);
        chk("r044_p1_bvalid", in1_if.bvalid, 0);
        chk("r044_bready",    out_if.bready, 0);
        @(negedge clk_i);
        s_bvalid = 0;
        @(negedge clk_i);
        s_bvalid = 1; s_bresp = 2'b11;
        #3;
        chk("r045_p0_bvalid", in0_if.bvalid, 0);
        chk("r045_p1_bvalid", in1_if.bvalid, 0);
        chk("r045_bready",    out_if.bready, 0);
        @(negedge clk_i);
        clear_inputs();

        // Randomized traffic; the compare process checks every cycle against the model.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk_i);
            rst_i = ($urandom_range(0, 399) == 0);
            for (int p = 0; p < 2; p++) begin
                m_awvalid[p] = $urandom_range(0, 1);
                m_awaddr[p]  = $urandom;
                m_wvalid[p]  = $urandom_range(0, 1);
                m_wdata[p]   = $urandom;
                m_wstrb[p]   = 4'($urandom_range(0, 15));
                m_bready[p]  = $urandom_range(0, 1);
                m_arvalid[p] = $urandom_range(0, 1);
                m_araddr[p]  = $urandom;
                m_rready[p]  = $urandom_range(0, 1);
            end
            s_awready = $urandom_range(0, 1);
            s_wready  = $urandom_range(0, 1);
            s_bvalid  = ($urandom_range(0, 2) == 0);
            s_bresp   = 2'($urandom_range(0, 3));
            s_arready = $urandom_range(0, 1);
            s_rvalid  = ($urandom_range(0, 2) == 0);
            s_rdata   = $urandom;
            s_rresp   = 2'($urandom_range(0, 3));
        end
        @(negedge clk_i);
        rst_i = 0;
        clear_inputs();
        @(negedge clk_i);
        #4;
        cmp_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
